// File: rtl/flp_to_int_4_pipeline.sv
// Pipelined binary32 -> int32 converter, round-to-nearest-even, saturating.
// Optional status flags (flag_invalid, flag_inexact) are built when FLP_TO_INT_FLAGS_EN is defined.
`timescale 1ns/1ps

module flp_to_int_4_pipeline (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] A,
    output logic        out_valid,
    output logic [31:0] result
`ifdef FLP_TO_INT_FLAGS_EN
    ,
    output logic        flag_invalid,
    output logic        flag_inexact
`endif
);

    // Capture register: the operand sampled at edge N leaves S4 at edge N+4.
    logic        in_v;
    logic [31:0] in_a;

    // NOTE: every clocked block uses non-blocking assignments so all stages shift together on one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_v <= 1'b0;
            in_a <= '0;
        end else begin
            in_v <= in_valid;
            in_a <= A;
        end
    end

    // S1: unpack and classify.
    logic        s1_v, s1_sign, s1_nan, s1_inf;
    logic [7:0]  s1_exp;
    logic [23:0] s1_mant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v    <= 1'b0;
            s1_sign <= 1'b0;
            s1_nan  <= 1'b0;
            s1_inf  <= 1'b0;
            s1_exp  <= '0;
            s1_mant <= '0;
        end else begin
            s1_v    <= in_v;
            s1_sign <= in_a[31];
            s1_exp  <= in_a[30:23];
            s1_mant <= {|in_a[30:23], in_a[22:0]};
            s1_nan  <= (&in_a[30:23]) & (|in_a[22:0]);
            s1_inf  <= (&in_a[30:23]) & ~(|in_a[22:0]);
        end
    end

    // S2: align mant * 2^(e-150). Shift amounts use modular low bits, valid in each branch's range.
    logic [3:0]  ls_amt;
    logic [4:0]  rs_amt;
    logic [55:0] rs_ext;
    logic        exact_min;
    logic [31:0] al_mag;
    logic        al_guard, al_sticky, al_ovf;

    assign ls_amt    = s1_exp[3:0] - 4'd6;
    assign rs_amt    = 5'd22 - s1_exp[4:0];
    assign rs_ext    = {s1_mant, 32'd0} >> rs_amt;
    assign exact_min = s1_sign & (s1_exp == 8'd158) & (s1_mant[22:0] == 23'd0);

    // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latches).
    always_comb begin
        al_mag    = '0;
        al_guard  = 1'b0;
        al_sticky = 1'b0;
        al_ovf    = 1'b0;
        if (s1_exp >= 8'd158) begin
            al_mag = exact_min ? 32'h8000_0000 : 32'h0;
            al_ovf = ~exact_min & ~s1_nan & ~s1_inf;
        end else if (s1_exp >= 8'd150) begin
            al_mag = {8'd0, s1_mant} << ls_amt;
        end else if (s1_exp >= 8'd126) begin
            al_mag    = {8'd0, rs_ext[55:32]};
            al_guard  = rs_ext[31];
            al_sticky = |rs_ext[30:0];
        end else begin
            al_sticky = |s1_mant;
        end
    end

    logic        s2_v, s2_sign, s2_nan, s2_inf, s2_ovf, s2_guard, s2_sticky;
    logic [31:0] s2_mag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_v      <= 1'b0;
            s2_sign   <= 1'b0;
            s2_nan    <= 1'b0;
            s2_inf    <= 1'b0;
            s2_ovf    <= 1'b0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
            s2_mag    <= '0;
        end else begin
            s2_v      <= s1_v;
            s2_sign   <= s1_sign;
            s2_nan    <= s1_nan;
            s2_inf    <= s1_inf;
            s2_ovf    <= al_ovf;
            s2_guard  <= al_guard;
            s2_sticky <= al_sticky;
            s2_mag    <= al_mag;
        end
    end

    // S3: RNE increment; rounding only happens below 2^24, so the add never carries out.
    logic        round_inc;
    logic        s3_v, s3_sign, s3_nan, s3_sat;
    logic [31:0] s3_mag;
`ifdef FLP_TO_INT_FLAGS_EN
    logic        s3_inexact;
`endif

    assign round_inc = s2_guard & (s2_sticky | s2_mag[0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s3_v       <= 1'b0;
            s3_sign    <= 1'b0;
            s3_nan     <= 1'b0;
            s3_sat     <= 1'b0;
            s3_mag     <= '0;
`ifdef FLP_TO_INT_FLAGS_EN
            s3_inexact <= 1'b0;
`endif
        end else begin
            s3_v       <= s2_v;
            s3_sign    <= s2_sign;
            s3_nan     <= s2_nan;
            s3_sat     <= s2_inf | s2_ovf;
            s3_mag     <= s2_mag + {31'd0, round_inc};
`ifdef FLP_TO_INT_FLAGS_EN
            s3_inexact <= (s2_guard | s2_sticky) & ~(s2_nan | s2_inf | s2_ovf);
`endif
        end
    end

    // S4: apply sign, saturate out-of-range and Inf, force NaN to the integer indefinite value.
    logic [31:0] s4_val;

    always_comb begin
        s4_val = s3_sign ? (32'd0 - s3_mag) : s3_mag;
        if (s3_nan)
            s4_val = 32'h8000_0000;
        else if (s3_sat)
            s4_val = s3_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end

`ifdef FLP_TO_INT_FLAGS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            result       <= '0;
            flag_invalid <= 1'b0;
            flag_inexact <= 1'b0;
        end else begin
            out_valid    <= s3_v;
            result       <= s4_val;
            flag_invalid <= s3_v & (s3_nan | s3_sat);
            flag_inexact <= s3_v & s3_inexact;
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            out_valid <= s3_v;
            result    <= s4_val;
        end
    end
`endif

endmodule

// File: tb/tb_flp_to_int_4_pipeline.sv
// Self-checking bench for flp_to_int_4_pipeline: directed vector table, streaming and reset
// sequences, then random operands against a real-arithmetic reference model.
`timescale 1ns/1ps

module tb_flp_to_int_4_pipeline;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] A;
    logic        out_valid;
    logic [31:0] result;
`ifdef FLP_TO_INT_FLAGS_EN
    logic        flag_invalid;
    logic        flag_inexact;
`endif

    flp_to_int_4_pipeline dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .A            (A),
        .out_valid    (out_valid),
        .result       (result)
`ifdef FLP_TO_INT_FLAGS_EN
        ,
        .flag_invalid (flag_invalid),
        .flag_inexact (flag_inexact)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] r;
        logic        inv;
        logic        inx;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] r;
        logic        inv;
        logic        inx;
        int          due;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference: exact value from the float fields, rounded half-to-even with floor arithmetic.
    task automatic model(input logic [31:0] a, output logic [31:0] r, output logic inv, output logic inx);
        int     e;
        int     fr;
        real    v, fl, d;
        longint k;
        e   = int'(a[30:23]);
        fr  = int'(a[22:0]);
        r   = 32'd0;
        inv = 1'b0;
        inx = 1'b0;
        if (e == 255) begin
            inv = 1'b1;
            r   = (fr != 0 || a[31]) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (e == 0) begin
            inx = (fr != 0);
        end else begin
            v = real'(fr + 8388608) * (2.0 ** (e - 150));
            if (a[31]) v = -v;
            fl = $floor(v);
            d  = v - fl;
            if (fl >= 2147483648.0) begin
                inv = 1'b1;
                r   = 32'h7FFF_FFFF;
            end else if (fl < -2147483648.0) begin
                inv = 1'b1;
                r   = 32'h8000_0000;
            end else begin
                k = longint'(fl);
                if (d > 0.5 || (d == 0.5 && k[0])) k++;
                inx = (d != 0.0);
                r   = k[31:0];
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check($sformatf("out_valid a=%h", e.a), {31'd0, out_valid}, 32'd1);
            check($sformatf("result a=%h", e.a), result, e.r);
`ifdef FLP_TO_INT_FLAGS_EN
            check($sformatf("flag_invalid a=%h", e.a), {31'd0, flag_invalid}, {31'd0, e.inv});
            check($sformatf("flag_inexact a=%h", e.a), {31'd0, flag_inexact}, {31'd0, e.inx});
`endif
        end else begin
            check("out_valid idle", {31'd0, out_valid}, 32'd0);
`ifdef FLP_TO_INT_FLAGS_EN
            check("flags idle", {30'd0, flag_invalid, flag_inexact}, 32'd0);
`endif
        end
    endtask

    // Called at a falling edge: drive, let one rising edge pass, then check at the next falling edge.
    task automatic tick(input logic [31:0] a, input logic v, input logic [31:0] r,
                        input logic inv, input logic inx);
        exp_t e;
        A        = a;
        in_valid = v;
        if (v) begin
            e.a   = a;
            e.r   = r;
            e.inv = inv;
            e.inx = inx;
            e.due = cyc + 5;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        monitor();
    endtask

    task automatic tick_model(input logic [31:0] a, input logic v);
        logic [31:0] r;
        logic        inv, inx;
        model(a, r, inv, inx);
        tick(a, v, r, inv, inx);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs[19];
    logic [31:0] stream_ops[6];

    initial begin
        vecs[0]  = '{32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0};
        vecs[1]  = '{32'hBFC0_0000, 32'hFFFF_FFFE, 1'b0, 1'b1};
        vecs[2]  = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0};
        vecs[3]  = '{32'h4020_0000, 32'h0000_0002, 1'b0, 1'b1};
        vecs[4]  = '{32'h4060_0000, 32'h0000_0004, 1'b0, 1'b1};
        vecs[5]  = '{32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1};
        vecs[6]  = '{32'h3ECC_CCCD, 32'h0000_0000, 1'b0, 1'b1};
        vecs[7]  = '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0};
        vecs[8]  = '{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0};
        vecs[9]  = '{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0};
        vecs[10] = '{32'h7FC0_0000, 32'h8000_0000, 1'b1, 1'b0};
        vecs[11] = '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[12] = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1};
        vecs[13] = '{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0};
        vecs[14] = '{32'hFFC0_0000, 32'h8000_0000, 1'b1, 1'b0};
        vecs[15] = '{32'h4F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0};
        vecs[16] = '{32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0};
        vecs[17] = '{32'h3FC0_0000, 32'h0000_0002, 1'b0, 1'b1};
        vecs[18] = '{32'h0080_0000, 32'h0000_0000, 1'b0, 1'b1};

        in_valid = 1'b0;
        A        = 32'h0;
        rst      = 1'b1;
        #1 rst   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset result", result, 32'd0);
`ifdef FLP_TO_INT_FLAGS_EN
        check("reset flags", {30'd0, flag_invalid, flag_inexact}, 32'd0);
`endif
        rst = 1'b1;
        idle(2);

        // Directed table, back to back.
        for (int i = 0; i < 19; i++) tick(vecs[i].a, 1'b1, vecs[i].r, vecs[i].inv, vecs[i].inx);
        idle(6);

        // Streaming: six operands with a bubble after the third.
        stream_ops[0] = 32'h4120_0000;
        stream_ops[1] = 32'hC2C8_0000;
        stream_ops[2] = 32'h3FE0_0000;
        stream_ops[3] = 32'h4B80_0001;
        stream_ops[4] = 32'hC0A0_0000;
        stream_ops[5] = 32'h4680_0000;
        for (int i = 0; i < 3; i++) tick_model(stream_ops[i], 1'b1);
        idle(1);
        for (int i = 3; i < 6; i++) tick_model(stream_ops[i], 1'b1);
        idle(6);

        // Reset mid-stream: first operand is on the output, the rest are in flight.
        for (int i = 0; i < 5; i++) tick_model(32'h4100_0000 + (i << 20), 1'b1);
        #2 rst = 1'b0;
        #1;
        check("out_valid on async reset", {31'd0, out_valid}, 32'd0);
        check("result on async reset", result, 32'd0);
        sb.delete();
        in_valid = 1'b0;
        @(negedge clk);
        idle(2);
        rst = 1'b1;
        idle(3);
        tick_model(32'hC1F8_0000, 1'b1);
        idle(6);

        // Random operands, biased toward the rounding and saturation exponents, with random bubbles.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            logic [7:0]  ex;
            ex = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(118, 162)) : 8'($urandom_range(0, 255));
            a  = {1'($urandom_range(0, 1)), ex, 23'($urandom)};
            if ($urandom_range(0, 7) == 0) a[21:0] = '0;
            tick_model(a, $urandom_range(0, 4) != 0);
        end
        idle(8);
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flp_to_int_4_pipeline.md
# flp_to_int_4_pipeline

Four-stage pipelined converter from IEEE-754 single precision to signed 32-bit integer, round-to-nearest-even, saturating. Sits beside the 7-stage FLP adder: it consumes packed FLP words, such as the adder's `sum`, and unpacks them back to integers for control and debug paths. It runs at one conversion per clock with a valid bit travelling alongside the data.

## Interface
- No parameters. Widths are fixed by the binary32 / int32 formats.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `A` carries an operand this cycle.
- `A`  in  32  binary32 operand: sign `A[31]`, exponent `A[30:23]`, fraction `A[22:0]`.
- `out_valid`  out  1  `result` holds a converted value this cycle.
- `result`  out  32  two's-complement integer.
- `flag_invalid`  out  1  present only with `FLP_TO_INT_FLAGS_EN`.
- `flag_inexact`  out  1  present only with `FLP_TO_INT_FLAGS_EN`.

## Operation
- **S1, unpack.** Register the sign, the exponent `e` and the 24-bit mantissa. The hidden bit is 1 when `e != 0`.
  - Classify the operand as NaN (`e=255`, frac≠0), Inf (`e=255`, frac=0) or zero/denormal (`e=0`).
  - Denormals are flushed to zero.
- **S2, align.** Value = mant × 2^(e−150).
  - `e ≥ 150` and `e ≤ 157`: shift left by `e−150`. The result is exact.
  - `126 ≤ e < 150`: shift right by `150−e`. Keep the guard bit (first bit dropped) and sticky (OR of all lower dropped bits).
  - `e < 126`: magnitude is below 0.5, so the magnitude is 0 and sticky = 1 if the operand is nonzero.
  - `e ≥ 158`: out of range, except the exact value −2^31 (`A = 0xCF000000`), which is representable.
- **S3, round (RNE).** Increment the magnitude when `guard & (sticky | lsb)`.
  - A carry cannot overflow 32 bits, because rounding only occurs for magnitudes below 2^24.
- **S4, sign/saturate.**
  - Negate when the sign is 1.
  - Out of range or Inf: +max `0x7FFFFFFF` or −max `0x80000000` by sign.
  - NaN: `0x80000000`, regardless of sign.
  - Zero/denormal: `0x00000000`.
- No backpressure. Every valid input produces exactly one output.
- `in_valid=0` inserts a bubble: the valid bit propagates as 0, and data in bubble slots is don't-care but must not raise `out_valid`.

## Timing
- Latency is 4 cycles. An operand sampled with `in_valid=1` at rising edge N appears with `out_valid=1` after rising edge N+4.
- Throughput is one operand per cycle. Back-to-back inputs yield back-to-back outputs in the same order.
- Reset values: `out_valid=0`, `result=0x00000000`, `flag_invalid=0`, `flag_inexact=0`. All stage valid bits and stage registers reset to 0.
- Assertion of `rst` (low) mid-stream discards every in-flight operand immediately, asynchronously. No output appears for them.
- After release, the first operand with `in_valid=1` emerges 4 edges later.
- Outputs are registered and hold their value until the next edge. `result` may change while `out_valid=0`.

## Configuration
- Macro: `FLP_TO_INT_FLAGS_EN`.
- **Defined:**
  - Ports `flag_invalid` and `flag_inexact` exist. Both are registered in S4 and aligned with `out_valid`.
  - `flag_invalid=1` for NaN, ±Inf, or an out-of-range finite value. It is 0 for −2^31.
  - `flag_inexact=1` when a finite in-range conversion discarded nonzero bits (guard|sticky, including nonzero denormals).
  - Both flags are 0 whenever `out_valid=0`.
- **Undefined:** the flag ports and flag logic are absent. `result` and `out_valid` behave identically to the defined case.

## Test plan
- Basic conversions, each sampled with `in_valid=1` at edge N and checked after edge N+4:
  - `A=0x3F800000` (1.0) → `result=0x00000001`.
  - `0xBFC00000` (−1.5) → `0xFFFFFFFE`.
  - `0x4EFFFFFF` → `0x7FFFFF80`.
- Ties to even:
  - `0x40200000` (2.5) → `0x00000002`, inexact=1.
  - `0x40600000` (3.5) → `0x00000004`.
  - `0x3F000000` (0.5) → `0x00000000`.
  - `0x3ECCCCCD` (0.4) → `0x00000000`, inexact=1.
- Saturation:
  - `0x4F000000` (2^31) → `0x7FFFFFFF`, invalid=1.
  - `0xCF000000` → `0x80000000`, invalid=0.
  - `0xFF800000` (−Inf) → `0x80000000`, invalid=1.
  - `0x7FC00000` (NaN) → `0x80000000`, invalid=1.
- Specials:
  - `0x80000000` (−0) → `0x00000000`, inexact=0.
  - Denormal `0x00000001` → `0x00000000`, inexact=1.
- Streaming: 6 consecutive operands with a one-cycle bubble after the third → `out_valid` pattern 1,1,1,0,1,1,1 starting at edge N+4, values in order.
- Reset mid-stream: pull `rst` low while 3 operands are in flight → `out_valid` drops to 0 at once. After release, none of the 3 ever appear, and a new operand emerges 4 edges later.
